// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   arb_state_t        - arbiter sequencing states
//   PORT_CPU, PORT_DBG - requester indices used for grant / last_grant
//   RD_LAT_MIN/MAX     - legal range of the memory read latency
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's handshake bundle towards the arbiter.
//   req   - request level, held until ready
//   wr    - 1 = write, 0 = read; stable while req is high
//   addr  - byte address, any alignment
//   wdata - write data
//   ready - one-cycle completion pulse
//   rdata - read data, valid with ready on a read and then held
// Modports: master = requester side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12
);

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;

    modport master (output req, wr, addr, wdata, input ready, rdata);
    modport slave  (input req, wr, addr, wdata, output ready, rdata);

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req0, req1 - pending requests
//   last_grant - index granted most recently
//   grant      - chosen index (meaningful only when valid)
//   valid      - at least one request pending
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    // On a tie the port that did not win last time goes next; otherwise the
    // single requester wins (grant falls back to 0 when nobody asks).
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-banked unified memory between the CPU
// (port 0) and the debug/loader port (port 1).
//   clk, rst     - clock and synchronous active-high reset
//   cpu, dbg     - requester handshakes (mem_port_arbiter_if.slave)
//   mem_a/mem_di - memory byte address / write data, held through the access
//   mem_wr       - single-cycle write strobe, only ever high in ACCESS
//   mem_do       - memory read data, valid RD_LAT cycles after the address
//   busy         - high whenever an access is being sequenced
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave cpu,
    mem_port_arbiter_if.slave dbg,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_di,
    output logic              mem_wr,
    input  logic [31:0]       mem_do,
    output logic              busy
);

    // Out-of-range latencies are clamped so the wait counter never wraps.
    localparam int LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [1:0] WAIT_LOAD = 2'(LAT_C - 1);

    arb_state_t  state;
    logic        last_grant;
    logic        gnt;
    logic        lat_wr;
    logic [1:0]  wait_cnt;
    logic        cpu_ready_r;
    logic        dbg_ready_r;
    logic [31:0] cpu_rdata_r;
    logic [31:0] dbg_rdata_r;
    logic        pick;
    logic        pick_valid;

    rr_arb2 u_rr (
        .req0       (cpu.req),
        .req1       (dbg.req),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign cpu.ready = cpu_ready_r;
    assign cpu.rdata = cpu_rdata_r;
    assign dbg.ready = dbg_ready_r;
    assign dbg.rdata = dbg_rdata_r;
    assign busy      = (state != IDLE);

    // Sequencer. The request fields are latched straight into mem_a/mem_di on
    // grant, so the non-granted port (and later changes on the granted one)
    // cannot disturb the access. Ready is set on the edge entering DONE so the
    // pulse is visible during DONE itself; mem_wr and ready default to 0 on
    // every other edge, which makes both exactly one cycle wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= PORT_DBG;
            gnt         <= PORT_CPU;
            lat_wr      <= 1'b0;
            wait_cnt    <= '0;
            mem_a       <= '0;
            mem_di      <= '0;
            mem_wr      <= 1'b0;
            cpu_ready_r <= 1'b0;
            dbg_ready_r <= 1'b0;
            cpu_rdata_r <= '0;
            dbg_rdata_r <= '0;
        end else begin
            mem_wr      <= 1'b0;
            cpu_ready_r <= 1'b0;
            dbg_ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt        <= pick;
                        last_grant <= pick;
                        lat_wr     <= (pick == PORT_DBG) ? dbg.wr    : cpu.wr;
                        mem_wr     <= (pick == PORT_DBG) ? dbg.wr    : cpu.wr;
                        mem_a      <= (pick == PORT_DBG) ? dbg.addr  : cpu.addr;
                        mem_di     <= (pick == PORT_DBG) ? dbg.wdata : cpu.wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_wr) begin
                        if (gnt == PORT_DBG) dbg_ready_r <= 1'b1;
                        else                 cpu_ready_r <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        if (gnt == PORT_DBG) begin
                            dbg_rdata_r <= mem_do;
                            dbg_ready_r <= 1'b1;
                        end else begin
                            cpu_rdata_r <= mem_do;
                            cpu_ready_r <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: runs two arbiters side by side (RD_LAT=1 and RD_LAT=3),
// each with its own byte-banked memory, against a transaction-level model that
// schedules every access by arithmetic on cycle numbers.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 12;
    localparam int MEM_SIZE   = 1 << ADDR_W;
    localparam int LAT0       = 1;
    localparam int LAT1       = 3;
    localparam int N_CYCLES   = 2500;
    localparam int RAND_START = 40;
    localparam int RAND_END   = 2400;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                at;
    } req_t;

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] data;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst    [2];
    logic [ADDR_W-1:0] mem_a  [2];
    logic [31:0]       mem_di [2];
    logic              mem_wr [2];
    logic [31:0]       mem_do [2];
    logic              busy   [2];

    // Port k = 2*env + port (port 0 = CPU, 1 = DBG).
    logic              drv_req   [4];
    logic              drv_wr    [4];
    logic [ADDR_W-1:0] drv_addr  [4];
    logic [31:0]       drv_wdata [4];
    logic              obs_ready [4];
    logic [31:0]       obs_rdata [4];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) cpu0 ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) dbg0 ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) cpu1 ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) dbg1 ();

    assign cpu0.req = drv_req[0]; assign cpu0.wr = drv_wr[0];
    assign cpu0.addr = drv_addr[0]; assign cpu0.wdata = drv_wdata[0];
    assign dbg0.req = drv_req[1]; assign dbg0.wr = drv_wr[1];
    assign dbg0.addr = drv_addr[1]; assign dbg0.wdata = drv_wdata[1];
    assign cpu1.req = drv_req[2]; assign cpu1.wr = drv_wr[2];
    assign cpu1.addr = drv_addr[2]; assign cpu1.wdata = drv_wdata[2];
    assign dbg1.req = drv_req[3]; assign dbg1.wr = drv_wr[3];
    assign dbg1.addr = drv_addr[3]; assign dbg1.wdata = drv_wdata[3];
    assign obs_ready[0] = cpu0.ready; assign obs_rdata[0] = cpu0.rdata;
    assign obs_ready[1] = dbg0.ready; assign obs_rdata[1] = dbg0.rdata;
    assign obs_ready[2] = cpu1.ready; assign obs_rdata[2] = cpu1.rdata;
    assign obs_ready[3] = dbg1.ready; assign obs_rdata[3] = dbg1.rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(LAT0)) dut0 (
        .clk    (clk),
        .rst    (rst[0]),
        .cpu    (cpu0),
        .dbg    (dbg0),
        .mem_a  (mem_a[0]),
        .mem_di (mem_di[0]),
        .mem_wr (mem_wr[0]),
        .mem_do (mem_do[0]),
        .busy   (busy[0])
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(LAT1)) dut1 (
        .clk    (clk),
        .rst    (rst[1]),
        .cpu    (cpu1),
        .dbg    (dbg1),
        .mem_a  (mem_a[1]),
        .mem_di (mem_di[1]),
        .mem_wr (mem_wr[1]),
        .mem_do (mem_do[1]),
        .busy   (busy[1])
    );

    // Memories driven by the DUTs: little-endian 32-bit access at any byte
    // address, wrapping at the top; read data appears RD_LAT cycles after the
    // address is sampled.
    bit   [7:0]  env_mem [2][MEM_SIZE];
    logic [31:0] rd_pipe [2][4];

    function automatic logic [31:0] rdEnv(input int e, input logic [ADDR_W-1:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = env_mem[e][ADDR_W'(a + b)];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int e = 0; e < 2; e++) begin
            if (mem_wr[e] === 1'b1)
                for (int b = 0; b < 4; b++)
                    env_mem[e][ADDR_W'(mem_a[e] + b)] <= mem_di[e][8*b +: 8];
            rd_pipe[e][0] <= rdEnv(e, mem_a[e]);
            for (int s = 1; s < 4; s++) rd_pipe[e][s] <= rd_pipe[e][s-1];
        end
    end

    assign mem_do[0] = rd_pipe[0][LAT0-1];
    assign mem_do[1] = rd_pipe[1][LAT1-1];

    // Reference model state.
    bit   [7:0]  ref_mem   [2][MEM_SIZE];
    req_t        rq        [4][$];
    req_t        cur       [4];
    bit          act       [4];
    logic [31:0] exp_rdata [4];
    bit          tr_valid  [2];
    int          tr_start  [2];
    int          tr_rdy    [2];
    int          tr_port   [2];
    req_t        tr        [2];
    logic [31:0] tr_rdval  [2];
    int          free_at   [2];
    int          last_g    [2];
    bit          post_rst  [2];
    int          rst_q     [2][$];
    done_t       log_q     [2][$];

    int vectors;
    int miscompares;
    int cyc;

    function automatic int lat(input int e);
        return (e == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [31:0] rdRef(input int e, input logic [ADDR_W-1:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = ref_mem[e][ADDR_W'(a + b)];
        return r;
    endfunction

    function automatic req_t mkReq(input logic wr, input logic [ADDR_W-1:0] a,
                                   input logic [31:0] d, input int at);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d; r.at = at;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int e,
                               input logic [31:0] act_v, input logic [31:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s env%0d cycle %0d: got %h, want %h",
                     name, e, cyc, act_v, exp_v);
        end
    endtask

    // Drive reset and both requesters of one environment for the current cycle.
    task automatic applyStimulus(input int e, output bit rst_now);
        rst_now = (cyc < 3);
        if (rst_q[e].size() > 0 && rst_q[e][0] == cyc) begin
            rst_now = 1'b1;
            void'(rst_q[e].pop_front());
        end
        if (cyc >= RAND_START && cyc < RAND_END && $urandom_range(0, 199) == 0)
            rst_now = 1'b1;
        rst[e] = rst_now;
        for (int p = 0; p < 2; p++) begin
            int k;
            k = 2*e + p;
            if (!act[k] && rq[k].size() == 0 && cyc >= RAND_START && cyc < RAND_END
                && $urandom_range(0, 2) == 0) begin
                logic [ADDR_W-1:0] a;
                a = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(MEM_SIZE-4, MEM_SIZE-1))
                                               : ADDR_W'($urandom_range(0, 63));
                rq[k].push_back(mkReq(1'($urandom_range(0, 1)), a, $urandom, cyc));
            end
            if (!act[k] && rq[k].size() > 0 && rq[k][0].at <= cyc) begin
                cur[k] = rq[k].pop_front();
                act[k] = 1'b1;
            end
            drv_req[k] = act[k];
            if (act[k]) begin
                drv_wr[k] = cur[k].wr; drv_addr[k] = cur[k].addr; drv_wdata[k] = cur[k].wdata;
            end else begin
                drv_wr[k] = 1'($urandom_range(0, 1));
                drv_addr[k] = ADDR_W'($urandom);
                drv_wdata[k] = $urandom;
            end
        end
    endtask

    // One cycle of one environment: check the outputs the DUT shows now,
    // retire model events, drive the next inputs and schedule new accesses.
    task automatic stepEnv(input int e);
        bit rst_now;
        if (tr_valid[e] && cyc == tr_rdy[e] && !tr[e].wr)
            exp_rdata[2*e + tr_port[e]] = tr_rdval[e];

        checkOutput("busy", e, 32'(busy[e]),
                    32'(tr_valid[e] && cyc > tr_start[e] && cyc <= tr_rdy[e]));
        checkOutput("mem_wr", e, 32'(mem_wr[e]),
                    32'(tr_valid[e] && tr[e].wr && cyc == tr_start[e] + 1));
        for (int p = 0; p < 2; p++) begin
            checkOutput(p == 0 ? "cpu_ready" : "dbg_ready", e, 32'(obs_ready[2*e+p]),
                        32'(tr_valid[e] && cyc == tr_rdy[e] && tr_port[e] == p));
            checkOutput(p == 0 ? "cpu_rdata" : "dbg_rdata", e, obs_rdata[2*e+p],
                        exp_rdata[2*e+p]);
            if (obs_ready[2*e+p] === 1'b1)
                log_q[e].push_back('{p, cyc, obs_rdata[2*e+p]});
        end
        if (tr_valid[e] && cyc > tr_start[e] && cyc < tr_rdy[e])
            checkOutput("mem_a", e, 32'(mem_a[e]), 32'(tr[e].addr));
        if (tr_valid[e] && tr[e].wr && cyc == tr_start[e] + 1)
            checkOutput("mem_di", e, mem_di[e], tr[e].wdata);
        if (post_rst[e]) begin
            checkOutput("mem_a_rst", e, 32'(mem_a[e]), 32'd0);
            checkOutput("mem_di_rst", e, mem_di[e], 32'd0);
        end

        if (tr_valid[e] && tr[e].wr && cyc == tr_start[e] + 1)
            for (int b = 0; b < 4; b++)
                ref_mem[e][ADDR_W'(tr[e].addr + b)] = tr[e].wdata[8*b +: 8];
        if (tr_valid[e] && cyc == tr_rdy[e]) begin
            tr_valid[e] = 1'b0;
            act[2*e + tr_port[e]] = 1'b0;
            free_at[e] = cyc + 1;
        end

        applyStimulus(e, rst_now);

        post_rst[e] = rst_now;
        if (rst_now) begin
            tr_valid[e] = 1'b0;
            exp_rdata[2*e] = '0;
            exp_rdata[2*e+1] = '0;
            last_g[e] = 1;
            free_at[e] = cyc + 1;
        end else if (cyc == free_at[e]) begin
            bit r0, r1;
            int w;
            r0 = act[2*e];
            r1 = act[2*e+1];
            if (!r0 && !r1) begin
                free_at[e] = cyc + 1;
            end else begin
                w = (r0 && r1) ? 1 - last_g[e] : (r1 ? 1 : 0);
                last_g[e]   = w;
                tr_valid[e] = 1'b1;
                tr_start[e] = cyc;
                tr_port[e]  = w;
                tr[e]       = cur[2*e + w];
                tr_rdy[e]   = cyc + 2 + (tr[e].wr ? 0 : lat(e));
                if (!tr[e].wr) tr_rdval[e] = rdRef(e, tr[e].addr);
            end
        end
    endtask

    task automatic pinLog(input int e, input int idx, input int port, input int c,
                          input bit chk_d, input logic [31:0] d);
        if (log_q[e].size() <= idx) begin
            checkOutput("pin_count", e, 32'(log_q[e].size()), 32'(idx + 1));
        end else begin
            checkOutput("pin_port", e, 32'(log_q[e][idx].port), 32'(port));
            checkOutput("pin_cycle", e, 32'(log_q[e][idx].cyc), 32'(c));
            if (chk_d) checkOutput("pin_rdata", e, log_q[e][idx].data, d);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = -1;
        for (int k = 0; k < 4; k++) begin
            drv_req[k] = 1'b0; drv_wr[k] = 1'b0; drv_addr[k] = '0; drv_wdata[k] = '0;
            act[k] = 1'b0; exp_rdata[k] = '0;
        end
        for (int e = 0; e < 2; e++) begin
            rst[e] = 1'b1; post_rst[e] = 1'b1; tr_valid[e] = 1'b0;
            free_at[e] = 0; last_g[e] = 1;
        end

        // Env 0 (RD_LAT=1): write, aligned read, unaligned read, reset in ACCESS.
        rq[0].push_back(mkReq(1'b1, 12'h010, 32'hDEADBEEF, 5));
        rq[0].push_back(mkReq(1'b0, 12'h010, 32'h0, 10));
        rq[0].push_back(mkReq(1'b0, 12'h011, 32'h0, 15));
        rq[0].push_back(mkReq(1'b1, 12'h030, 32'h12345678, 22));
        rst_q[0].push_back(23);
        // Env 1 (RD_LAT=3): simultaneous writes, then a dbg read with a CPU
        // write raised while it waits.
        rq[2].push_back(mkReq(1'b1, 12'h100, 32'hA1A1A1A1, 5));
        rq[2].push_back(mkReq(1'b1, 12'h104, 32'hA2A2A2A2, 5));
        rq[2].push_back(mkReq(1'b1, 12'h020, 32'hCAFEF00D, 18));
        rq[2].push_back(mkReq(1'b1, 12'h020, 32'h11111111, 23));
        rq[3].push_back(mkReq(1'b1, 12'h200, 32'hB1B1B1B1, 5));
        rq[3].push_back(mkReq(1'b1, 12'h204, 32'hB2B2B2B2, 5));
        rq[3].push_back(mkReq(1'b0, 12'h020, 32'h0, 21));

        for (cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            for (int e = 0; e < 2; e++) stepEnv(e);
        end

        pinLog(0, 0, 0, 7,  1'b0, 32'h0);
        pinLog(0, 1, 0, 13, 1'b1, 32'hDEADBEEF);
        pinLog(0, 2, 0, 18, 1'b1, 32'h00DEADBE);
        pinLog(0, 3, 0, 26, 1'b0, 32'h0);
        pinLog(1, 0, 0, 7,  1'b0, 32'h0);
        pinLog(1, 1, 1, 10, 1'b0, 32'h0);
        pinLog(1, 2, 0, 13, 1'b0, 32'h0);
        pinLog(1, 3, 1, 16, 1'b0, 32'h0);
        pinLog(1, 4, 0, 20, 1'b0, 32'h0);
        pinLog(1, 5, 1, 26, 1'b1, 32'hCAFEF00D);
        pinLog(1, 6, 0, 29, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
